// File: rtl/prog_memory_pkg.sv
// Shared definitions for the program memory: instruction encoding,
// the HALT-based fill word and the FSM state encoding.
// Instruction word layout (16 bit): [15:11] opcode, [10:8] register, [7:0] immediate/address.
package prog_memory_pkg;

    localparam int OP_W  = 5;
    localparam int REG_W = 3;
    localparam int IMM_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_HALT  = 5'd0,
        OP_LOAD  = 5'd1,
        OP_STORE = 5'd2,
        OP_ADD   = 5'd3,
        OP_SUB   = 5'd4,
        OP_CMP   = 5'd5,
        OP_BNZ   = 5'd6,
        OP_JUMP  = 5'd7,
        OP_SHL   = 5'd8,
        OP_SHR   = 5'd9
    } opcode_t;

    typedef enum logic [REG_W-1:0] {
        R0 = 3'd0,
        R1 = 3'd1,
        R2 = 3'd2,
        R3 = 3'd3,
        R4 = 3'd4,
        R5 = 3'd5,
        R6 = 3'd6,
        R7 = 3'd7
    } reg_t;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    // Unwritten program space decodes as HALT so a runaway fetch stops the core.
    localparam logic [OP_W+REG_W+IMM_W-1:0] FILL_WORD_DEFAULT = {OP_HALT, 11'b0};

    function automatic logic [OP_W+REG_W+IMM_W-1:0] make_instr(
        input opcode_t          op,
        input reg_t             rd,
        input logic [IMM_W-1:0] imm
    );
        return {op, rd, imm};
    endfunction

endpackage

// File: rtl/prog_memory_if.sv
// Fetch, direct-write and streaming-load signals of the program memory.
// master = client side (fetch unit / loader), slave = the memory itself.
interface prog_memory_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) ();

    // fetch port
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dataout;
    // direct single-word write
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] datain;
    // streaming load
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic [ADDR_W:0]   ld_len;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    // status
    logic              busy;
    logic              ld_done;
    logic              wr_err;

    modport master (
        output addr, we, waddr, datain,
        output ld_start, ld_base, ld_len, ld_valid, ld_data,
        input  dataout, ld_ready, busy, ld_done, wr_err
    );

    modport slave (
        input  addr, we, waddr, datain,
        input  ld_start, ld_base, ld_len, ld_valid, ld_data,
        output dataout, ld_ready, busy, ld_done, wr_err
    );

endinterface

// File: rtl/prog_boot_rom.sv
// Combinational boot image used by the init sweep when the memory is built
// with PROG_MEMORY_BOOT_IMAGE_EN. Small self-test program:
//   0 LOAD  R1,[0x80]   1 ADD  R1,#1    2 STORE R1,[0x81]  3 CMP R1,#2
//   4 BNZ   0x08        5 SHL  R1,#1    6 SHR   R1,#1      7 JUMP 0x09
//   8 HALT  0xEE (fail trap)            9 HALT  0x00 (pass)
// Every other index returns FILL_WORD.
module prog_boot_rom
    import prog_memory_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_WORD_DEFAULT)
) (
    input  logic [ADDR_W-1:0] idx,
    output logic [DATA_W-1:0] word
);

    // index -> image word lookup
    always_comb begin
        word = FILL_WORD;
        case (idx)
            ADDR_W'(0): word = DATA_W'(make_instr(OP_LOAD,  R1, 8'h80));
            ADDR_W'(1): word = DATA_W'(make_instr(OP_ADD,   R1, 8'h01));
            ADDR_W'(2): word = DATA_W'(make_instr(OP_STORE, R1, 8'h81));
            ADDR_W'(3): word = DATA_W'(make_instr(OP_CMP,   R1, 8'h02));
            ADDR_W'(4): word = DATA_W'(make_instr(OP_BNZ,   R0, 8'h08));
            ADDR_W'(5): word = DATA_W'(make_instr(OP_SHL,   R1, 8'h01));
            ADDR_W'(6): word = DATA_W'(make_instr(OP_SHR,   R1, 8'h01));
            ADDR_W'(7): word = DATA_W'(make_instr(OP_JUMP,  R0, 8'h09));
            ADDR_W'(8): word = DATA_W'(make_instr(OP_HALT,  R0, 8'hEE));
            ADDR_W'(9): word = DATA_W'(make_instr(OP_HALT,  R0, 8'h00));
            default:    word = FILL_WORD;
        endcase
    end

endmodule

// File: rtl/prog_memory.sv
// Program memory with zero-latency fetch, a direct write port usable only
// when idle, and a streaming loader (ld_start / ld_valid / ld_ready).
// After every reset an init sweep writes each word once (one per cycle).
// Build option: PROG_MEMORY_BOOT_IMAGE_EN -- the sweep writes the boot image
// from prog_boot_rom instead of FILL_WORD.
module prog_memory
    import prog_memory_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_WORD_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst,
    prog_memory_if.slave bus
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

    state_t            state_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W:0]   remaining_reg;
    logic              ld_ready_reg;
    logic              ld_done_reg;
    logic              wr_err_reg;
    logic              busy_reg;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] init_word;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W:0]   len_clamped;

`ifdef PROG_MEMORY_BOOT_IMAGE_EN
    prog_boot_rom #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .FILL_WORD (FILL_WORD)
    ) u_boot_rom (
        .idx  (cnt_reg),
        .word (init_word)
    );
`else
    assign init_word = FILL_WORD;
`endif

    // A load can never cover more than the whole memory.
    assign len_clamped = (bus.ld_len > DEPTH_LEN) ? DEPTH_LEN : bus.ld_len;

    // Single RAM write port shared by init sweep, direct write and loader.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = cnt_reg;
        ram_wdata = init_word;
        if (!rst) begin
            case (state_reg)
                ST_INIT: ram_we = 1'b1;
                ST_IDLE: begin
                    if (bus.we) begin
                        ram_we    = 1'b1;
                        ram_waddr = bus.waddr;
                        ram_wdata = bus.datain;
                    end
                end
                ST_LOAD: begin
                    if (bus.ld_valid && ld_ready_reg) begin
                        ram_we    = 1'b1;
                        ram_waddr = ptr_reg;
                        ram_wdata = bus.ld_data;
                    end
                end
                default: ram_we = 1'b0;
            endcase
        end
    end

    // RAM array; contents are never reset, only rewritten by the sweep.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    // Fetch is asynchronous: a write lands on the edge and is seen after it.
    assign bus.dataout = mem[bus.addr];

    // Control FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_INIT;
            cnt_reg       <= '0;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            ld_ready_reg  <= 1'b0;
            ld_done_reg   <= 1'b0;
            wr_err_reg    <= 1'b0;
            busy_reg      <= 1'b1;
        end else begin
            ld_done_reg <= 1'b0;
            wr_err_reg  <= 1'b0;
            case (state_reg)
                ST_INIT: begin
                    // direct writes are dropped while the sweep owns the RAM
                    if (bus.we) begin
                        wr_err_reg <= 1'b1;
                    end
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ADDR) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (bus.ld_start) begin
                        ptr_reg       <= bus.ld_base;
                        remaining_reg <= len_clamped;
                        if (len_clamped == '0) begin
                            ld_done_reg <= 1'b1;
                        end else begin
                            state_reg    <= ST_LOAD;
                            ld_ready_reg <= 1'b1;
                            busy_reg     <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.we) begin
                        wr_err_reg <= 1'b1;
                    end
                    if (bus.ld_valid && ld_ready_reg) begin
                        ptr_reg       <= ptr_reg + 1'b1;
                        remaining_reg <= remaining_reg - 1'b1;
                        if (remaining_reg == (ADDR_W+1)'(1)) begin
                            state_reg    <= ST_IDLE;
                            ld_ready_reg <= 1'b0;
                            busy_reg     <= 1'b0;
                            ld_done_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg    <= ST_INIT;
                    cnt_reg      <= '0;
                    ld_ready_reg <= 1'b0;
                    busy_reg     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ld_ready = ld_ready_reg;
    assign bus.ld_done  = ld_done_reg;
    assign bus.wr_err   = wr_err_reg;
    assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_prog_memory.sv
// Scoreboard bench for prog_memory: stimulus pushes expected read data and
// expected ld_done / wr_err pulses into queues; a negedge monitor pops them.
module tb_prog_memory;

    localparam int DW = 16;
    localparam int AW = 8;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } rd_t;

    logic clk;
    logic rst;
    logic rd_strobe;

    rd_t  rd_q[$];
    int   done_q[$];
    int   err_q[$];

    int   checks;
    int   errors;
    logic prev_done;
    logic prev_err;

    prog_memory_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    prog_memory #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("check %s: 0x%0h ok", name, act);
        end
    endfunction

    // Expected content after the init sweep.
    function automatic logic [DW-1:0] exp_init(logic [AW-1:0] a);
`ifdef PROG_MEMORY_BOOT_IMAGE_EN
        case (a)
            8'd0: return 16'h0980;
            8'd1: return 16'h1901;
            8'd2: return 16'h1181;
            8'd3: return 16'h2902;
            8'd4: return 16'h3008;
            8'd5: return 16'h4101;
            8'd6: return 16'h4901;
            8'd7: return 16'h3809;
            8'd8: return 16'h00EE;
            default: return 16'h0000;
        endcase
`else
        return (a == a) ? 16'h0000 : 16'hFFFF;
`endif
    endfunction

    // Monitor: compares reads and consumes expected pulse tokens.
    always @(negedge clk) begin
        if (rd_strobe === 1'b1) begin
            if (rd_q.size() == 0) begin
                chk("read_queue_underflow", 32'd0, 32'd1);
            end else begin
                rd_t e;
                e = rd_q.pop_front();
                chk($sformatf("read@%02h", e.a), bus.dataout, e.d);
            end
        end
        if (bus.ld_done === 1'b1) begin
            chk("ld_done_expected", (done_q.size() != 0), 1);
            chk("ld_done_width", prev_done, 0);
            if (done_q.size() != 0) void'(done_q.pop_front());
        end
        if (bus.wr_err === 1'b1) begin
            chk("wr_err_expected", (err_q.size() != 0), 1);
            chk("wr_err_width", prev_err, 0);
            if (err_q.size() != 0) void'(err_q.pop_front());
        end
        prev_done = (bus.ld_done === 1'b1);
        prev_err  = (bus.wr_err === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input logic [AW-1:0] a, input logic [DW-1:0] d);
        rd_t e;
        e.a = a;
        e.d = d;
        bus.addr  = a;
        rd_strobe = 1'b1;
        rd_q.push_back(e);
        tick();
        rd_strobe = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n;
        n = 0;
        while (bus.ld_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("ld_ready_wait", bus.ld_ready, 1);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("ld_done_arrived", done_q.size(), 0);
    endtask

    initial begin
        int busy_bad;
        int ready_seen;
        checks = 0; errors = 0;
        prev_done = 1'b0; prev_err = 1'b0;
        rst = 1'b1; rd_strobe = 1'b0;
        bus.addr = '0; bus.we = 1'b0; bus.waddr = '0; bus.datain = '0;
        bus.ld_start = 1'b0; bus.ld_base = '0; bus.ld_len = '0;
        bus.ld_valid = 1'b0; bus.ld_data = '0;

        // reset state
        tick();
        tick();
        chk("rst_busy", bus.busy, 1);
        chk("rst_ld_ready", bus.ld_ready, 0);
        chk("rst_ld_done", bus.ld_done, 0);
        chk("rst_wr_err", bus.wr_err, 0);

        // init sweep: busy for exactly 256 cycles, write during INIT rejected
        rst = 1'b0;
        busy_bad = 0;
        for (int k = 1; k <= 256; k++) begin
            if (k == 10) begin
                bus.we = 1'b1; bus.waddr = 8'h20; bus.datain = 16'hBEEF;
                err_q.push_back(1);
            end
            if (k == 11) bus.we = 1'b0;
            tick();
            if (k < 256 && bus.busy !== 1'b1) busy_bad++;
        end
        chk("init_busy_cycles_low", busy_bad, 0);
        chk("init_done_busy", bus.busy, 0);
        chk("init_err_consumed", err_q.size(), 0);
        foreach (rd_q[i]) rd_q.delete(i);
        read_chk(8'h00, exp_init(8'h00));
        read_chk(8'h01, exp_init(8'h01));
        read_chk(8'h08, exp_init(8'h08));
        read_chk(8'h09, exp_init(8'h09));
        read_chk(8'h20, exp_init(8'h20));
        read_chk(8'h7F, exp_init(8'h7F));
        read_chk(8'hFF, exp_init(8'hFF));

        // direct write: old value in write cycle, new value after the edge
        bus.addr = 8'h10; bus.we = 1'b1; bus.waddr = 8'h10; bus.datain = 16'hA5A5;
        rd_strobe = 1'b1;
        rd_q.push_back('{a: 8'h10, d: exp_init(8'h10)});
        tick();
        bus.we = 1'b0;
        rd_q.push_back('{a: 8'h10, d: 16'hA5A5});
        tick();
        rd_strobe = 1'b0;

        // wrapping load with gaps, write and ld_start during LOAD
        bus.ld_start = 1'b1; bus.ld_base = 8'hFE; bus.ld_len = 9'd3;
        done_q.push_back(1);
        tick();
        bus.ld_start = 1'b0;
        chk("load_ready", bus.ld_ready, 1);
        chk("load_busy", bus.busy, 1);
        send(16'h1111);
        bus.ld_start = 1'b1; bus.ld_base = 8'h40; bus.ld_len = 9'd1;
        bus.we = 1'b1; bus.waddr = 8'h30; bus.datain = 16'hDEAD;
        err_q.push_back(1);
        tick();
        bus.ld_start = 1'b0; bus.we = 1'b0;
        tick();
        send(16'h2222);
        tick();
        tick();
        send(16'h3333);
        wait_done();
        chk("load_end_ready", bus.ld_ready, 0);
        chk("load_err_consumed", err_q.size(), 0);
        read_chk(8'hFE, 16'h1111);
        read_chk(8'hFF, 16'h2222);
        read_chk(8'h00, 16'h3333);
        read_chk(8'h30, exp_init(8'h30));
        read_chk(8'h40, exp_init(8'h40));

        // oversize length clamps to the full memory
        bus.ld_start = 1'b1; bus.ld_base = 8'h00; bus.ld_len = 9'd300;
        done_q.push_back(1);
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 256; i++) send(16'h5A00 + 16'(i));
        wait_done();
        chk("clamp_ready_low", bus.ld_ready, 0);
        chk("clamp_busy_low", bus.busy, 0);
        read_chk(8'h00, 16'h5A00);
        read_chk(8'h50, 16'h5A50);
        read_chk(8'hFF, 16'h5AFF);

        // zero-length load
        bus.ld_start = 1'b1; bus.ld_base = 8'h50; bus.ld_len = 9'd0;
        done_q.push_back(1);
        tick();
        bus.ld_start = 1'b0;
        chk("len0_done_next", bus.ld_done, 1);
        ready_seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.ld_ready === 1'b1 || bus.busy === 1'b1) ready_seen++;
            tick();
        end
        chk("len0_never_ready", ready_seen, 0);
        read_chk(8'h50, 16'h5A50);

        // ld_start and we in the same idle cycle
        bus.ld_start = 1'b1; bus.ld_base = 8'h60; bus.ld_len = 9'd1;
        bus.we = 1'b1; bus.waddr = 8'h61; bus.datain = 16'h7777;
        done_q.push_back(1);
        tick();
        bus.ld_start = 1'b0; bus.we = 1'b0;
        send(16'h6060);
        wait_done();
        read_chk(8'h60, 16'h6060);
        read_chk(8'h61, 16'h7777);

        // reset in the middle of a load
        bus.ld_start = 1'b1; bus.ld_base = 8'h20; bus.ld_len = 9'd4;
        tick();
        bus.ld_start = 1'b0;
        send(16'hC0DE);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 1);
        chk("midrst_ready", bus.ld_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (256) tick();
        chk("midrst_sweep_done", bus.busy, 0);
        read_chk(8'h20, exp_init(8'h20));
        read_chk(8'h21, exp_init(8'h21));
        read_chk(8'h60, exp_init(8'h60));

        tick();
        chk("done_queue_empty", done_q.size(), 0);
        chk("err_queue_empty", err_q.size(), 0);
        chk("read_queue_empty", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
